// File: rtl/stack_pkg.sv
// Shared stack defaults and the {push,pop} op encoding used by the controller.
// Latency: none (types and constants only).
// Backpressure: none (no handshake logic here).
package stack_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int DEPTH_DEF  = 8;

    // Encoding is literally {push,pop}, so the controller can drive the op directly
    typedef enum logic [1:0] {
        OP_NOP  = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_REPL = 2'b11
    } stack_op_e;

endpackage

// File: rtl/stack_ram.sv
// DEPTH x DATA_W register array, one synchronous write port, one asynchronous read port.
// Latency: write lands on the rising edge; read is combinational from the address.
// Backpressure: none; out-of-range writes are dropped and out-of-range reads return 0.
module stack_ram #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8,
    parameter int AW     = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     wa,
    input  logic [DATA_W-1:0] wd,
    input  logic [AW-1:0]     ra,
    output logic [DATA_W-1:0] rd
);

    localparam logic [AW-1:0] DEPTH_A = AW'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];

    // Storage is deliberately not reset; only the top level's count decides what is valid
    always_ff @(posedge clk) begin
        if (we && (wa < DEPTH_A)) begin
            mem[wa] <= wd;
        end
    end

    // Addresses past the last entry show up when count < 2; return 0 rather than X
    assign rd = (ra < DEPTH_A) ? mem[ra] : '0;

endmodule

// File: rtl/cpu_stack_unit.sv
// Operand/return stack with registered top-of-stack, occupancy count and sticky error flags.
// Latency: 1 cycle from push/pop to tos/count; back-to-back ops with no bubble.
// Backpressure: none; push when full / pop when empty are dropped and flagged sticky.
module cpu_stack_unit
    import stack_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    input  logic              clr_err,
    output logic [DATA_W-1:0] tos,
    output logic [CNT_W-1:0]  count,
    output logic              empty,
    output logic              full,
    output logic              overflow,
    output logic              underflow
);

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO      = CNT_W'(2);

    stack_op_e         op;
    logic              we;
    logic [CNT_W-1:0]  wa;
    logic [CNT_W-1:0]  ra;
    logic [DATA_W-1:0] rd_dat;
    logic [CNT_W-1:0]  count_nxt;
    logic [DATA_W-1:0] tos_nxt;
    logic              ovf_evt;
    logic              unf_evt;

    assign op    = stack_op_e'({push, pop});
    assign empty = (count == '0);
    assign full  = (count == FULL_CNT);

    // After a pop the new top is the entry just below the current top
    assign ra = count - TWO;

    stack_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (CNT_W)
    ) u_ram (
        .clk (clk),
        .we  (we),
        .wa  (wa),
        .wd  (din),
        .ra  (ra),
        .rd  (rd_dat)
    );

    // Op decode: next count/tos, RAM write and error events
    always_comb begin
        we        = 1'b0;
        wa        = count;
        count_nxt = count;
        tos_nxt   = tos;
        ovf_evt   = 1'b0;
        unf_evt   = 1'b0;
        case (op)
            OP_PUSH: begin
                if (!full) begin
                    we        = 1'b1;
                    wa        = count;
                    count_nxt = count + ONE;
                    tos_nxt   = din;
                end else begin
                    ovf_evt   = 1'b1;
                end
            end
            OP_POP: begin
                if (!empty) begin
                    count_nxt = count - ONE;
                    tos_nxt   = (count == ONE) ? '0 : rd_dat;
                end else begin
                    unf_evt   = 1'b1;
                end
            end
            OP_REPL: begin
                we      = 1'b1;
                tos_nxt = din;
                if (!empty) begin
                    // Overwrite the top in place; occupancy is unchanged even when full
                    wa = count - ONE;
                end else begin
                    // Nothing to pop: the push half still goes through
                    wa        = count;
                    count_nxt = ONE;
                    unf_evt   = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    // Count and registered top-of-stack
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
            tos   <= '0;
        end else begin
            count <= count_nxt;
            tos   <= tos_nxt;
        end
    end

    // Sticky flags: a same-cycle error event beats clr_err
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (ovf_evt) begin
                overflow <= 1'b1;
            end else if (clr_err) begin
                overflow <= 1'b0;
            end
            if (unf_evt) begin
                underflow <= 1'b1;
            end else if (clr_err) begin
                underflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cpu_stack_unit.sv
module tb_cpu_stack_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        push8, pop8, clr8;
    logic [7:0]  din8, tos8;
    logic [3:0]  cnt8;
    logic        e8, f8, o8, u8;
    logic        push16, pop16, clr16;
    logic [15:0] din16, tos16;
    logic [2:0]  cnt16;
    logic        e16, f16, o16, u16;

    cpu_stack_unit #(.DATA_W(8), .DEPTH(8)) dut8 (
        .clk(clk), .rst(rst), .push(push8), .pop(pop8), .din(din8), .clr_err(clr8),
        .tos(tos8), .count(cnt8), .empty(e8), .full(f8), .overflow(o8), .underflow(u8)
    );

    cpu_stack_unit #(.DATA_W(16), .DEPTH(5)) dut16 (
        .clk(clk), .rst(rst), .push(push16), .pop(pop16), .din(din16), .clr_err(clr16),
        .tos(tos16), .count(cnt16), .empty(e16), .full(f16), .overflow(o16), .underflow(u16)
    );

    typedef struct {
        bit          wide;
        bit          push;
        bit          pop;
        bit          clr;
        logic [15:0] din;
        logic [15:0] tos;
        logic [3:0]  cnt;
        bit          e;
        bit          f;
        bit          o;
        bit          u;
        string       name;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int   passed = 0;
    int   total  = 0;

    task automatic chk(input string n, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", n, got, exp);
    endtask

    task automatic add(input bit w, input bit p, input bit q, input bit c,
                       input logic [15:0] d, input logic [15:0] t, input logic [3:0] n,
                       input bit e, input bit f, input bit o, input bit u, input string nm);
        vec_t v;
        v.wide = w; v.push = p; v.pop = q; v.clr = c; v.din = d; v.tos = t; v.cnt = n;
        v.e = e; v.f = f; v.o = o; v.u = u; v.name = nm;
        vecs.push_back(v);
    endtask

    task automatic drive_idle();
        push8 = 0; pop8 = 0; clr8 = 0; din8 = '0;
        push16 = 0; pop16 = 0; clr16 = 0; din16 = '0;
    endtask

    task automatic check_out();
        vec_t x;
        if (sb.size() == 0) begin
            total++;
            $display("FAIL scoreboard: no expected entry queued");
            return;
        end
        x = sb.pop_front();
        if (x.wide) begin
            chk({x.name, ".tos"},   tos16, x.tos);
            chk({x.name, ".count"}, {13'h0, cnt16}, {12'h0, x.cnt});
            chk({x.name, ".flags"}, {12'h0, e16, f16, o16, u16}, {12'h0, x.e, x.f, x.o, x.u});
        end else begin
            chk({x.name, ".tos"},   {8'h0, tos8}, x.tos);
            chk({x.name, ".count"}, {12'h0, cnt8}, {12'h0, x.cnt});
            chk({x.name, ".flags"}, {12'h0, e8, f8, o8, u8}, {12'h0, x.e, x.f, x.o, x.u});
        end
    endtask

    task automatic apply(input vec_t v);
        @(negedge clk);
        drive_idle();
        if (v.wide) begin
            push16 = v.push; pop16 = v.pop; clr16 = v.clr; din16 = v.din;
        end else begin
            push8 = v.push; pop8 = v.pop; clr8 = v.clr; din8 = v.din[7:0];
        end
        sb.push_back(v);
        @(posedge clk);
        #1;
        check_out();
    endtask

    task automatic chk_reset_state(input string n);
        chk({n, ".tos8"},    {8'h0, tos8}, 16'h0);
        chk({n, ".flags8"},  {11'h0, cnt8 == 4'd0, e8, f8, o8, u8}, 16'h0018);
        chk({n, ".tos16"},   tos16, 16'h0);
        chk({n, ".flags16"}, {11'h0, cnt16 == 3'd0, e16, f16, o16, u16}, 16'h0018);
    endtask

    initial begin
        drive_idle();
        rst = 1'b0;
        #1;
        chk_reset_state("por");
        @(negedge clk);
        rst = 1'b1;

        // push three, pop three
        add(0,1,0,0, 16'h11, 16'h11, 1, 0,0,0,0, "p11");
        add(0,1,0,0, 16'h22, 16'h22, 2, 0,0,0,0, "p22");
        add(0,1,0,0, 16'h33, 16'h33, 3, 0,0,0,0, "p33");
        add(0,0,1,0, 16'h00, 16'h22, 2, 0,0,0,0, "pop3");
        add(0,0,1,0, 16'h00, 16'h11, 1, 0,0,0,0, "pop2");
        add(0,0,1,0, 16'h00, 16'h00, 0, 1,0,0,0, "pop1");
        // underflow and clr_err priority
        add(0,0,1,0, 16'h00, 16'h00, 0, 1,0,0,1, "pop_empty");
        add(0,0,1,1, 16'h00, 16'h00, 0, 1,0,0,1, "clr_vs_pop");
        add(0,0,0,1, 16'h00, 16'h00, 0, 1,0,0,0, "clr_only");
        // fill to DEPTH, then overflow
        for (int i = 1; i <= 8; i++)
            add(0,1,0,0, 16'(i), 16'(i), 4'(i), 0, i == 8, 0,0, $sformatf("fill%0d", i));
        add(0,1,0,0, 16'hFF, 16'h08, 8, 0,1,1,0, "push_full");
        add(0,1,0,1, 16'hFE, 16'h08, 8, 0,1,1,0, "clr_vs_push_full");
        add(0,1,1,0, 16'h77, 16'h77, 8, 0,1,1,0, "repl_full");
        add(0,0,0,1, 16'h00, 16'h77, 8, 0,1,0,0, "clr_ovf");
        for (int c = 7; c >= 0; c--)
            add(0,0,1,0, 16'h00, 16'(c), 4'(c), c == 0, 0,0,0, $sformatf("drain%0d", c));
        // replace top with two entries
        add(0,1,0,0, 16'hAA, 16'hAA, 1, 0,0,0,0, "pAA");
        add(0,1,0,0, 16'hBB, 16'hBB, 2, 0,0,0,0, "pBB");
        add(0,1,1,0, 16'hCC, 16'hCC, 2, 0,0,0,0, "replCC");
        add(0,0,1,0, 16'h00, 16'hAA, 1, 0,0,0,0, "pop_after_repl");
        add(0,0,1,0, 16'h00, 16'h00, 0, 1,0,0,0, "pop_last");
        // push&pop on empty
        add(0,1,1,0, 16'h5A, 16'h5A, 1, 0,0,0,1, "repl_empty");
        add(0,0,1,1, 16'h00, 16'h00, 0, 1,0,0,0, "pop_clr");
        // wide, shallow instance
        for (int i = 1; i <= 5; i++)
            add(1,1,0,0, 16'h1000 + 16'(i), 16'h1000 + 16'(i), 4'(i), 0, i == 5, 0,0,
                $sformatf("w_push%0d", i));
        add(1,1,0,0, 16'hBEEF, 16'h1005, 5, 0,1,1,0, "w_push6");
        for (int c = 4; c >= 0; c--)
            add(1,0,1,0, 16'h0, (c == 0) ? 16'h0 : 16'h1000 + 16'(c), 4'(c), c == 0, 0,1,0,
                $sformatf("w_pop%0d", c));

        foreach (vecs[i]) apply(vecs[i]);

        // async reset dropped mid-push, with a sticky flag set beforehand
        add(0,0,1,0, 16'h00, 16'h00, 0, 1,0,0,1, "pre_rst_unf");
        add(0,1,0,0, 16'h44, 16'h44, 1, 0,0,0,1, "pre_rst_p44");
        apply(vecs[vecs.size()-2]);
        apply(vecs[vecs.size()-1]);
        @(negedge clk);
        drive_idle();
        push8 = 1; din8 = 8'h55;
        @(posedge clk);
        #2;
        chk("mid_push.count", {12'h0, cnt8}, 16'd2);
        #1;
        rst = 1'b0;
        #1;
        chk_reset_state("async_rst");
        @(posedge clk);
        #1;
        chk("rst_hold.count", {12'h0, cnt8}, 16'd0);
        @(negedge clk);
        rst = 1'b1;
        drive_idle();
        add(0,1,0,0, 16'h66, 16'h66, 1, 0,0,0,0, "post_rst_p66");
        apply(vecs[vecs.size()-1]);

        @(negedge clk);
        drive_idle();
        if (sb.size() != 0) begin
            total++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
